// File: rtl/data_bus_pkg.sv
// Shared encodings for the data-bus master: access sizes, response error
// codes, master FSM states, the latched request attributes, and the
// size-dependent helpers used at request acceptance.
package data_bus_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CNT_WIDTH  = 8;   // holds TIMEOUT-1 for TIMEOUT <= 255

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam logic [1:0] ERR_NONE         = 2'b00;
  localparam logic [1:0] ERR_MISALIGNED   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT      = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL_SIZE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Request attributes captured at acceptance.
  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       is_unsigned;
  } req_attr_t;

  // Keep only the bytes that belong to the access size.
  function automatic logic [DATA_WIDTH-1:0] mask_wdata(input logic [1:0] size,
                                                       input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] m;
    case (size)
      SIZE_BYTE: m = {24'b0, w[7:0]};
      SIZE_HALF: m = {16'b0, w[15:0]};
      default:   m = w;
    endcase
    return m;
  endfunction

  // Half needs 2-byte alignment, word 4-byte; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = (addr_lo != 2'b00);
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_bus_master_load_extend.sv
// load_extend: sign/zero extension of right-aligned load data.
// Ports: size (access size), is_unsigned (zero-extend when 1),
//        raw (right-aligned data), ext (extended 32-bit result).
module load_extend
  import data_bus_pkg::*;
(
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SIZE_BYTE: ext = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      SIZE_HALF: ext = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/data_bus_master.sv
// data_bus_master: turns single load/store requests into rd/wd strobe cycles
// on the data bus, checks size/alignment locally, extends load data and
// returns one response (with error code) per request.
// Ports: clk/rst (async active-high); req_* request handshake and payload;
//        resp_* one-cycle response; bus_* strobes, address/size/data toward
//        the responder plus its ready/busy/read-data inputs.
module data_bus_master
  import data_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  bus_rd,
  output logic                  bus_wd,
  input  logic                  bus_ready,
  input  logic                  bus_busy,
  output logic [1:0]            bus_size_in,
  output logic [1:0]            bus_size_out,
  output logic [ADDR_WIDTH-1:0] bus_addr_in,
  output logic [ADDR_WIDTH-1:0] bus_addr_out,
  output logic [DATA_WIDTH-1:0] bus_data_in,
  input  logic [DATA_WIDTH-1:0] bus_data_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_e                state_q, state_d;
  req_attr_t             attr_q, attr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [1:0]            resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic                  strobe;
  logic [DATA_WIDTH-1:0] load_ext;

  // Strobe follows the responder handshake combinationally so the access
  // completes in the first ISSUE cycle the responder can take it.
  assign strobe = (state_q == ISSUE) && bus_ready && !bus_busy;
  assign bus_rd = strobe && !attr_q.write;
  assign bus_wd = strobe &&  attr_q.write;

  load_extend u_load_extend (
    .size        (attr_q.size),
    .is_unsigned (attr_q.is_unsigned),
    .raw         (bus_data_out),
    .ext         (load_ext)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    attr_d       = attr_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = ERR_NONE;
    resp_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          attr_d = '{write: req_write, size: req_size, is_unsigned: req_unsigned};
          if (req_size == SIZE_ILLEGAL) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = ERR_ILLEGAL_SIZE;
          end else if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = ERR_MISALIGNED;
          end else begin
            state_d = ISSUE;
            cnt_d   = '0;
            addr_d  = req_addr;
            size_d  = req_size;
            wdata_d = mask_wdata(req_size, req_wdata);
          end
        end
      end
      ISSUE: begin
        if (strobe) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          if (!attr_q.write) resp_rdata_d = load_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      attr_q       <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= ERR_NONE;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      attr_q       <= attr_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;
  // Read and write views share one latched address/size so the responder
  // never sees a mismatched pair.
  assign bus_addr_in  = addr_q;
  assign bus_addr_out = addr_q;
  assign bus_size_in  = size_q;
  assign bus_size_out = size_q;
  assign bus_data_in  = wdata_q;

endmodule

// File: tb/tb_data_bus_master.sv
// Self-checking bench for data_bus_master: directed cases plus randomized
// requests and responder behaviour, checked against a behavioural model.
module tb_data_bus_master;

  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic [1:0]    resp_err;
  logic          bus_rd;
  logic          bus_wd;
  logic          bus_ready;
  logic          bus_busy;
  logic [1:0]    bus_size_in;
  logic [1:0]    bus_size_out;
  logic [AW-1:0] bus_addr_in;
  logic [AW-1:0] bus_addr_out;
  logic [31:0]   bus_data_in;
  logic [31:0]   bus_data_out;

  int n_checks = 0;
  int n_errors = 0;

  data_bus_master #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .bus_rd       (bus_rd),
    .bus_wd       (bus_wd),
    .bus_ready    (bus_ready),
    .bus_busy     (bus_busy),
    .bus_size_in  (bus_size_in),
    .bus_size_out (bus_size_out),
    .bus_addr_in  (bus_addr_in),
    .bus_addr_out (bus_addr_out),
    .bus_data_in  (bus_data_in),
    .bus_data_out (bus_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected error code from the access rules (checked before any bus cycle).
  function automatic logic [1:0] model_err(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'd3) return 2'd3;
    if (sz == 2'd1 && (addr % 2) != 0) return 2'd1;
    if (sz == 2'd2 && (addr % 4) != 0) return 2'd1;
    return 2'd0;
  endfunction

  // Expected load result: low bytes kept, upper bytes copied from the sign bit
  // of the accessed size unless unsigned.
  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] d);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = d % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = d % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return w % 256;
    if (sz == 2'd1) return w % 65536;
    return w;
  endfunction

  // One request end to end. mode: 0 random responder, 1 always ready,
  // 2 always busy, 3 busy until the last allowed ISSUE cycle.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int mode);
    logic [1:0]  e;
    logic [31:0] exp_rdata;
    logic        strobe;
    strobe    = 1'b0;
    exp_rdata = '0;
    e = model_err(sz, addr);

    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    bus_ready    = 1'b1;
    bus_busy     = 1'b0;
    #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_resp_valid", 32'(resp_valid), 32'd0);
    check("idle_strobe", 32'({bus_rd, bus_wd}), 32'd0);

    @(negedge clk);
    // Held/garbage request while busy must be ignored.
    req_valid    = 1'($urandom_range(0, 1));
    req_write    = 1'($urandom_range(0, 1));
    req_size     = 2'($urandom_range(0, 3));
    req_addr     = $urandom;
    req_wdata    = $urandom;

    if (e == 2'd0) begin
      for (int k = 0; k < int'(TO); k++) begin
        case (mode)
          1: begin bus_ready = 1'b1; bus_busy = 1'b0; end
          2: begin bus_ready = 1'b1; bus_busy = 1'b1; end
          3: begin bus_ready = 1'b1; bus_busy = (k < int'(TO) - 1); end
          default: begin
            bus_ready = ($urandom_range(0, 3) != 0);
            bus_busy  = ($urandom_range(0, 2) == 0);
          end
        endcase
        bus_data_out = rdata;
        #1;
        strobe = bus_ready && !bus_busy;
        check("issue_resp_valid", 32'(resp_valid), 32'd0);
        check("issue_req_ready", 32'(req_ready), 32'd0);
        check("bus_rd", 32'(bus_rd), 32'(strobe && !wr));
        check("bus_wd", 32'(bus_wd), 32'(strobe && wr));
        check("bus_addr_in", bus_addr_in, addr);
        check("bus_addr_out", bus_addr_out, addr);
        check("bus_size_in", 32'(bus_size_in), 32'(sz));
        check("bus_size_out", 32'(bus_size_out), 32'(sz));
        check("bus_data_in", bus_data_in, model_wdata(sz, wd));
        @(negedge clk);
        if (strobe) break;
      end
      if (strobe) exp_rdata = wr ? 32'd0 : model_load(sz, uns, rdata);
      else        e = 2'd2;
    end

    // Response cycle: responder offers a transfer to expose any stray strobe.
    bus_ready = 1'b1;
    bus_busy  = 1'b0;
    #1;
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_err", 32'(resp_err), 32'(e));
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_req_ready", 32'(req_ready), 32'd0);
    check("resp_strobe", 32'({bus_rd, bus_wd}), 32'd0);
    if (model_err(sz, addr) == 2'd0) check("resp_addr_hold", bus_addr_out, addr);
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    bus_ready    = 1'b0;
    bus_busy     = 1'b0;
    bus_data_out = '0;

    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_strobe", 32'({bus_rd, bus_wd}), 32'd0);
    check("rst_bus_addr", bus_addr_in | bus_addr_out, 32'd0);
    check("rst_bus_size", 32'({bus_size_in, bus_size_out}), 32'd0);
    check("rst_bus_data", bus_data_in, 32'd0);
    rst = 1'b0;

    // Directed cases.
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8000_00F1, 1);
    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h0000_00F1, 1);
    do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'h0000_00F1, 1);
    do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1);
    do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 32'h0, 1);
    do_req(1'b0, 2'd3, 1'b0, 32'h23, 32'h0, 32'h0, 1);
    do_req(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 32'h0, 1);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0000_8001, 1);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h0000_8001, 1);
    do_req(1'b1, 2'd0, 1'b0, 32'h33, 32'h1234_56A5, 32'h0, 1);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h5555_AAAA, 2);
    do_req(1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFE_F00D, 32'h0, 2);
    do_req(1'b0, 2'd2, 1'b0, 32'h108, 32'h0, 32'h1357_9BDF, 3);

    // Reset while a load is stalled in ISSUE.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h40;
    bus_ready = 1'b1;
    bus_busy  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("stall_bus_rd", 32'(bus_rd), 32'd0);
    @(negedge clk);
    bus_busy = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_mid_bus_rd", 32'(bus_rd), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      check("post_rst_req_ready", 32'(req_ready), 32'd1);
      check("post_rst_bus_rd", 32'(bus_rd), 32'd0);
    end

    // Randomized requests and responder behaviour.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, $urandom, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
